// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared constants and FSM state type for the I2C target
package i2c_pkg;

  localparam int   BYTE_W   = 8;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_slave_responder_if.sv
// rtl/i2c_slave_responder_if.sv - I2C pins plus core-side word handshake
interface i2c_slave_responder_if
  import i2c_pkg::*;
#(
  parameter int ADD_range  = 7,
  parameter int WORD_BYTES = 3
);

  logic                         scl_in;
  logic                         sda_in;
  logic                         sda_oe;
  logic [ADD_range-1:0]         CS_address;
  logic [BYTE_W*WORD_BYTES-1:0] wr_data;
  logic                         wr_valid;
  logic [BYTE_W*WORD_BYTES-1:0] rd_data;
  logic                         rd_req;
  logic                         rd_done;
  logic                         busy;

  modport slave (
    input  scl_in, sda_in, CS_address, rd_data,
    output sda_oe, wr_data, wr_valid, rd_req, rd_done, busy
  );

  modport master (
    output scl_in, sda_in, CS_address, rd_data,
    input  sda_oe, wr_data, wr_valid, rd_req, rd_done, busy
  );

endinterface

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizers, edge and START/STOP detection
// I2C_GLITCH_FILTER_EN adds a 3-sample stable filter after each synchronizer.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_s, sda_s;
  logic                   scl_line, sda_line;
  logic                   scl_prev, sda_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= SYNC_STAGES'({scl_sync, scl_in});
      sda_sync <= SYNC_STAGES'({sda_sync, sda_in});
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_hist <= '1;
      sda_hist <= '1;
    end else begin
      scl_hist <= {scl_hist[0], scl_s};
      sda_hist <= {sda_hist[0], sda_s};
    end
  end

  // The prev flop doubles as the filter's held output value.
  assign scl_line = (scl_s == scl_hist[0] && scl_s == scl_hist[1]) ? scl_s : scl_prev;
  assign sda_line = (sda_s == sda_hist[0] && sda_s == sda_hist[1]) ? sda_s : sda_prev;
`else
  assign scl_line = scl_s;
  assign sda_line = sda_s;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_prev  <= 1'b1;
      sda_prev  <= 1'b1;
      sda_lvl   <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_prev  <= scl_line;
      sda_prev  <= sda_line;
      sda_lvl   <= sda_line;
      scl_rise  <= scl_line & ~scl_prev;
      scl_fall  <= ~scl_line & scl_prev;
      start_det <= scl_line & scl_prev & sda_prev & ~sda_line;
      stop_det  <= scl_line & scl_prev & ~sda_prev & sda_line;
    end
  end

endmodule

// File: rtl/i2c_slave_responder.sv
// rtl/i2c_slave_responder.sv - I2C target moving one multi-byte word per transfer
// Build with I2C_GLITCH_FILTER_EN to enable line glitch filtering.
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter int ADD_range   = 7,
  parameter int WORD_BYTES  = 3,
  parameter int SYNC_STAGES = 2
) (
  input logic                  clk,
  input logic                  reset,
  i2c_slave_responder_if.slave bus
);

  localparam int WORD_W = BYTE_W * WORD_BYTES;
  localparam int HDR_W  = ADD_range + 1;
  localparam int CNT_W  = $clog2(HDR_W + BYTE_W + 1);
  localparam int BCNT_W = $clog2(WORD_BYTES + 1);

  localparam logic [CNT_W-1:0]  HDR_BITS  = CNT_W'(HDR_W);
  localparam logic [CNT_W-1:0]  BYTE_BITS = CNT_W'(BYTE_W);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(WORD_BYTES);
  localparam logic [BCNT_W-1:0] LAST_M1   = BCNT_W'(WORD_BYTES - 1);

  logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (bus.scl_in),
    .sda_in    (bus.sda_in),
    .sda_lvl   (sda_lvl),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e         state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BCNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [HDR_W-1:0]   hdr_q, hdr_d;
  logic               rw_q, rw_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [WORD_W-1:0]  rd_sr_q, rd_sr_d;
  logic [WORD_W-1:0]  wr_data_q, wr_data_d;
  logic               sda_oe_q, sda_oe_d;
  logic               busy_q, busy_d;
  logic               wr_valid_q, wr_valid_d;
  logic               rd_done_q, rd_done_d;
  logic               rd_req_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      hdr_q      <= '0;
      rw_q       <= 1'b0;
      word_q     <= '0;
      rd_sr_q    <= '0;
      wr_data_q  <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      hdr_q      <= hdr_d;
      rw_q       <= rw_d;
      word_q     <= word_d;
      rd_sr_q    <= rd_sr_d;
      wr_data_q  <= wr_data_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      rd_done_q  <= rd_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    hdr_d      = hdr_q;
    rw_d       = rw_q;
    word_d     = word_q;
    rd_sr_d    = rd_sr_q;
    wr_data_d  = wr_data_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    rd_done_d  = 1'b0;
    rd_req_c   = 1'b0;

    case (state_q)
      ADDR: begin
        if (scl_rise && bit_cnt_q < HDR_BITS) begin
          hdr_d     = {hdr_q[HDR_W-2:0], sda_lvl};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (scl_fall && bit_cnt_q == HDR_BITS) begin
          bit_cnt_d = '0;
          rw_d      = hdr_q[0];
          if (hdr_q[HDR_W-1:1] == bus.CS_address) begin
            state_d  = ADDR_ACK;
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
            if (hdr_q[0]) begin
              rd_req_c = 1'b1;
              rd_sr_d  = bus.rd_data;
            end
          end else begin
            state_d = IGNORE;
          end
        end
      end

      ADDR_ACK: begin
        if (scl_fall) begin
          byte_cnt_d = '0;
          if (rw_q) begin
            // First data bit goes out on the same fall that ends the ACK slot.
            state_d   = RD_BYTE;
            sda_oe_d  = ~rd_sr_q[WORD_W-1];
            rd_sr_d   = {rd_sr_q[WORD_W-2:0], 1'b0};
            bit_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            state_d   = WR_BYTE;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
          end
        end
      end

      WR_BYTE: begin
        if (scl_rise && bit_cnt_q < BYTE_BITS) begin
          word_d    = {word_q[WORD_W-2:0], sda_lvl};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (scl_fall && bit_cnt_q == BYTE_BITS) begin
          state_d    = WR_ACK;
          sda_oe_d   = 1'b1;
          bit_cnt_d  = '0;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST_M1) begin
            wr_data_d  = word_q;
            wr_valid_d = 1'b1;
          end
        end
      end

      WR_ACK: begin
        if (scl_fall) begin
          sda_oe_d = 1'b0;
          state_d  = (byte_cnt_q < LAST_BYTE) ? WR_BYTE : IGNORE;
        end
      end

      RD_BYTE: begin
        if (scl_fall) begin
          if (bit_cnt_q == BYTE_BITS) begin
            state_d    = RD_ACK;
            sda_oe_d   = 1'b0;
            bit_cnt_d  = '0;
            byte_cnt_d = byte_cnt_q + 1'b1;
          end else begin
            sda_oe_d  = ~rd_sr_q[WORD_W-1];
            rd_sr_d   = {rd_sr_q[WORD_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      RD_ACK: begin
        if (scl_rise) begin
          if (sda_lvl == I2C_NACK || byte_cnt_q == LAST_BYTE) begin
            rd_done_d = 1'b1;
            state_d   = IGNORE;
          end else if (sda_lvl == I2C_ACK) begin
            state_d = RD_BYTE;
          end
        end
      end

      IGNORE: sda_oe_d = 1'b0;

      IDLE: ;

      default: state_d = IDLE;
    endcase

    // Bus conditions override whatever the byte engine decided this cycle.
    if (start_det) begin
      state_d    = ADDR;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      word_d     = '0;
      sda_oe_d   = 1'b0;
      rd_req_c   = 1'b0;
      wr_valid_d = 1'b0;
    end else if (stop_det) begin
      state_d    = IDLE;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      wr_valid_d = 1'b0;
    end
  end

  assign bus.sda_oe   = sda_oe_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.rd_req   = rd_req_c;
  assign bus.rd_done  = rd_done_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb/tb_i2c_slave_responder.sv - directed I2C master bench with word scoreboard
module tb_i2c_slave_responder;

  localparam int Q = 50;

  logic clk = 1'b0;
  logic reset;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  always #5 clk = ~clk;

  i2c_slave_responder_if #(.ADD_range(7), .WORD_BYTES(3)) bus ();

  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  i2c_slave_responder #(.ADD_range(7), .WORD_BYTES(3), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr = 0, n_rdreq = 0, n_rddone = 0, n_oe = 0, n_busy = 0, n_unexp = 0;
  int b_wr, b_rdreq, b_rddone, b_oe, b_busy;
  logic [23:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic        ack;
  logic [7:0]  d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.wr_valid) begin
        n_wr++;
        if (exp_wr.size() > 0) check("wr_data", {8'h0, bus.wr_data}, {8'h0, exp_wr.pop_front()});
        else n_unexp++;
      end
      if (bus.rd_req)  n_rdreq++;
      if (bus.rd_done) n_rddone++;
      if (bus.sda_oe)  n_oe++;
      if (bus.busy)    n_busy++;
    end
  end

  task automatic snap();
    b_wr = n_wr; b_rdreq = n_rdreq; b_rddone = n_rddone; b_oe = n_oe; b_busy = n_busy;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic clock_bit(input logic b, output logic r);
    sda_m = b; #Q; scl_m = 1'b1; #Q; r = bus.sda_in; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
    clock_bit(1'b1, a);
  endtask

  task automatic wr_checked(input string tag, input logic [7:0] b, input logic exp_ack);
    logic a;
    write_byte(b, a);
    check(tag, {31'h0, a}, {31'h0, exp_ack});
  endtask

  task automatic rd_checked(input string tag, input logic master_ack);
    logic r;
    logic [7:0] v = 8'h0;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, r);
      v = {v[6:0], r};
    end
    clock_bit(master_ack, r);
    check(tag, {24'h0, v}, {24'h0, exp_rd.pop_front()});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.CS_address = 7'b1000101;
    bus.rd_data = 24'h0;
    #3;
    check("rst_sda_oe",   {31'h0, bus.sda_oe},   32'h0);
    check("rst_wr_data",  {8'h0, bus.wr_data},   32'h0);
    check("rst_wr_valid", {31'h0, bus.wr_valid}, 32'h0);
    check("rst_rd_req",   {31'h0, bus.rd_req},   32'h0);
    check("rst_rd_done",  {31'h0, bus.rd_done},  32'h0);
    check("rst_busy",     {31'h0, bus.busy},     32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);

    // Plain 3-byte write
    snap();
    exp_wr.push_back(24'h3ABCDE);
    i2c_start();
    wr_checked("wr_hdr_ack", 8'h8A, 1'b0);
    wr_checked("wr_b0_ack",  8'h3A, 1'b0);
    wr_checked("wr_b1_ack",  8'hBC, 1'b0);
    wr_checked("wr_b2_ack",  8'hDE, 1'b0);
    check("wr_busy_high", {31'h0, bus.busy}, 32'h1);
    i2c_stop();
    check("wr_busy_after_stop", {31'h0, bus.busy}, 32'h0);
    check("wr_count", n_wr - b_wr, 1);
    check("wr_queue_drained", exp_wr.size(), 0);

    // Plain 3-byte read, master NACKs the last byte
    snap();
    bus.rd_data = 24'hA5C381;
    exp_rd.push_back(8'hA5); exp_rd.push_back(8'hC3); exp_rd.push_back(8'h81);
    i2c_start();
    wr_checked("rd_hdr_ack", 8'h8B, 1'b0);
    rd_checked("rd_b0", 1'b0);
    rd_checked("rd_b1", 1'b0);
    rd_checked("rd_b2", 1'b1);
    i2c_stop();
    check("rd_req_count",  n_rdreq - b_rdreq, 1);
    check("rd_done_count", n_rddone - b_rddone, 1);
    check("rd_busy_after_stop", {31'h0, bus.busy}, 32'h0);

    // Foreign address: bus must stay untouched
    snap();
    i2c_start();
    wr_checked("mm_hdr_nack",  8'h9A, 1'b1);
    wr_checked("mm_data_nack", 8'h55, 1'b1);
    i2c_stop();
    check("mm_oe_cycles",   n_oe - b_oe, 0);
    check("mm_busy_cycles", n_busy - b_busy, 0);
    check("mm_wr_count",    n_wr - b_wr, 0);
    check("mm_rdreq_count", n_rdreq - b_rdreq, 0);

    // Overrun: fourth byte NACKed, word keeps first three
    snap();
    exp_wr.push_back(24'h112233);
    i2c_start();
    wr_checked("ov_hdr_ack", 8'h8A, 1'b0);
    wr_checked("ov_b0_ack",  8'h11, 1'b0);
    wr_checked("ov_b1_ack",  8'h22, 1'b0);
    wr_checked("ov_b2_ack",  8'h33, 1'b0);
    wr_checked("ov_b3_nack", 8'h44, 1'b1);
    i2c_stop();
    check("ov_wr_count", n_wr - b_wr, 1);
    check("ov_wr_data",  {8'h0, bus.wr_data}, 32'h112233);

    // Abort after one data byte
    snap();
    i2c_start();
    wr_checked("ab_hdr_ack", 8'h8A, 1'b0);
    wr_checked("ab_b0_ack",  8'h55, 1'b0);
    i2c_stop();
    check("ab_wr_count", n_wr - b_wr, 0);
    check("ab_wr_data",  {8'h0, bus.wr_data}, 32'h112233);

    // Repeated start turns a partial write into a read
    snap();
    bus.rd_data = 24'h3C96E1;
    exp_rd.push_back(8'h3C); exp_rd.push_back(8'h96); exp_rd.push_back(8'hE1);
    i2c_start();
    wr_checked("rs_wr_hdr_ack", 8'h8A, 1'b0);
    wr_checked("rs_b0_ack",     8'h66, 1'b0);
    i2c_start();
    wr_checked("rs_rd_hdr_ack", 8'h8B, 1'b0);
    rd_checked("rs_b0", 1'b0);
    rd_checked("rs_b1", 1'b0);
    rd_checked("rs_b2", 1'b1);
    i2c_stop();
    check("rs_wr_count",   n_wr - b_wr, 0);
    check("rs_rdreq_count", n_rdreq - b_rdreq, 1);
    check("rs_rddone_count", n_rddone - b_rddone, 1);

    // Reset while the target is pulling SDA low for a 0 data bit
    bus.rd_data = 24'h00FFFF;
    i2c_start();
    wr_checked("rr_hdr_ack", 8'h8B, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("rr_oe_before_reset", {31'h0, bus.sda_oe}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rr_oe_async_release", {31'h0, bus.sda_oe}, 32'h0);
    check("rr_busy_cleared",     {31'h0, bus.busy},   32'h0);
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    snap();
    exp_wr.push_back(24'h010203);
    i2c_start();
    wr_checked("pr_hdr_ack", 8'h8A, 1'b0);
    wr_checked("pr_b0_ack",  8'h01, 1'b0);
    wr_checked("pr_b1_ack",  8'h02, 1'b0);
    wr_checked("pr_b2_ack",  8'h03, 1'b0);
    i2c_stop();
    check("pr_wr_count", n_wr - b_wr, 1);

`ifdef I2C_GLITCH_FILTER_EN
    // Two-clock SDA dip with SCL high must not be taken as START
    snap();
    @(negedge clk);
    sda_m = 1'b0;
    repeat (2) @(negedge clk);
    sda_m = 1'b1;
    repeat (10) @(posedge clk);
    scl_m = 1'b0; #Q;
    wr_checked("gl_hdr_nack", 8'h8A, 1'b1);
    i2c_stop();
    check("gl_busy_cycles", n_busy - b_busy, 0);
`endif

    check("wr_unexpected", n_unexp, 0);
    check("wr_queue_end", exp_wr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- Synthesizable I2C target (slave) for the adapter interface; the responder end to the I2C master driving SCL and SDA.
- Oversamples SCL/SDA on the system clock and decodes START, STOP and the 7-bit address + R/W header.
- Write transaction: receives a 24-bit word (3 bytes, MSB first) and presents it to the core.
- Read transaction: fetches a 24-bit word from the core and shifts it out. SDA is open-drain, driven low only.

Parameters:
- ADD_range, 7, slave address width in bits.
- WORD_BYTES, 3, data bytes per transaction; the word is 8*WORD_BYTES bits.
- SYNC_STAGES, 2, flip-flop stages in the SCL/SDA synchronizers.

Ports:
- clk  input  1  system clock; at least 8x the SCL frequency.
- reset  input  1  asynchronous, active-low reset.
- scl_in  input  1  raw SCL line.
- sda_in  input  1  raw SDA line.
- sda_oe  output  1  1 = pull SDA low, 0 = release (high-Z).
- CS_address  input  ADD_range  address this slave answers to.
- wr_data  output  8*WORD_BYTES  last received write word.
- wr_valid  output  1  one-cycle pulse when wr_data updates.
- rd_data  input  8*WORD_BYTES  word to return on a read.
- rd_req  output  1  one-cycle pulse; rd_data is captured in that same cycle.
- rd_done  output  1  one-cycle pulse after the last read byte's ACK slot.
- busy  output  1  high from an address match until STOP.

Behaviour:
- Reset values (reset=0, asynchronous): sda_oe=0, wr_data=0, wr_valid=0, rd_req=0, rd_done=0, busy=0, FSM=IDLE. Synchronizer flops reset to 1 (idle bus).
- Line conditioning:
  - SYNC_STAGES-flop synchronizers feed edge detectors.
  - Detection latency is SYNC_STAGES+1 clk from the pin.
  - START = SDA falls while SCL is high. STOP = SDA rises while SCL is high.
  - Data is sampled on a detected SCL rise. sda_oe changes only on a detected SCL fall.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- Global transitions, highest priority:
  - START in any state -> ADDR, including a repeated start: bit counter cleared, sda_oe=0.
  - STOP in any state -> IDLE: sda_oe=0, busy=0.
- ADDR:
  - Shift in 8 bits, MSB first.
  - On the SCL fall after bit 8: if the upper ADD_range bits equal CS_address -> ADDR_ACK with sda_oe=1 and busy=1; otherwise -> IGNORE.
  - If R/W=1, rd_req pulses on that same fall and rd_data is latched into the shift register.
- ADDR_ACK: on the next SCL fall, release, then go to WR_BYTE (R/W=0) or RD_BYTE (R/W=1). For a read, drive bit 23 immediately: sda_oe = ~bit.
- WR_BYTE:
  - 8 bits shift into the word register.
  - On the 8th-bit fall, go to WR_ACK and drive ACK (sda_oe=1).
  - After byte WORD_BYTES: wr_data <= word and wr_valid pulses in that cycle.
- WR_ACK:
  - Release on the next fall.
  - If fewer than WORD_BYTES bytes received -> WR_BYTE; otherwise -> IGNORE.
  - Further write bytes are NACKed (SDA released).
- RD_BYTE:
  - On each SCL fall, drive the next bit: sda_oe=1 for a 0 bit, 0 for a 1 bit.
  - After the 8th bit's fall, release and go to RD_ACK.
- RD_ACK:
  - Sample SDA on the SCL rise.
  - ACK (0) with bytes remaining -> RD_BYTE, driving the next MSB on the following fall.
  - NACK, or the last byte done -> rd_done pulse, then IGNORE.
- IGNORE: sda_oe=0; wait for START or STOP.
- Boundary cases:
  - STOP mid-byte: partial write data is discarded and wr_valid does not fire.
  - START and STOP are never both detected in one cycle; START wins.
  - SCL held high indefinitely: no state change.
  - Reset mid-transfer releases SDA immediately.

Optional Feature:
- Macro: I2C_GLITCH_FILTER_EN.
- Defined: each synchronized line feeds a 3-sample stable filter; the filtered value changes only after 3 equal consecutive samples. Detection latency grows by 2 clk and pulses shorter than 3 clk are rejected.
- Undefined: no filter, synchronizer output used directly.

Decomposition:
- Package i2c_pkg holds:
  - the state enum typedef;
  - constants I2C_ACK=1'b0, I2C_NACK=1'b1 and BYTE_W=8.
- Sub-module i2c_line_sync (sync + optional filter + rise/fall/START/STOP detection), instantiated once for SCL/SDA together.

Test Plan:
- Write: CS_address=7'b1000101; master sends START, 0x8A, 0x3A, 0xBC, 0xDE, STOP -> ACK on all 4 slots; wr_valid once with wr_data=24'h3ABCDE; busy low after STOP.
- Read: rd_data=24'hA5C381; master sends START, 0x8B, ACK, ACK, NACK, STOP -> rd_req once; master reads 0xA5, 0xC3, 0x81; rd_done once.
- Address mismatch: header 0x9A -> SDA never driven (sda_oe stays 0); no wr_valid or rd_req; busy stays 0.
- Overrun and abort:
  - 4 write data bytes -> the 4th byte is NACKed; wr_data holds the first 3 bytes.
  - STOP after 1 data byte -> no wr_valid.
- Repeated start: write header 0x8A, 1 data byte, then START + 0x8B -> read proceeds normally; no wr_valid.
- Reset: assert reset during RD_BYTE with sda_oe=1 -> sda_oe=0 asynchronously; FSM returns to IDLE. With I2C_GLITCH_FILTER_EN defined, a 2-clk SDA low pulse while SCL is high produces no START.
